// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan capture path.
// Contents:
//   - digit count and code width
//   - 5-bit character codes for the non-hex glyphs
//   - 7-bit active-low segment patterns (bit0 = a ... bit6 = g)
//   - anode classification type and helper
package seg_pkg;

    localparam int DIGITS = 4;
    localparam int CODE_W = 5;
    localparam int SEG_W  = 7;
    localparam int SAMPLE_W = DIGITS + SEG_W;

    // Character codes beyond the hex range 0x00-0x0F
    localparam logic [CODE_W-1:0] CODE_L     = 5'h10;
    localparam logic [CODE_W-1:0] CODE_H     = 5'h11;
    localparam logic [CODE_W-1:0] CODE_P     = 5'h12;
    localparam logic [CODE_W-1:0] CODE_U     = 5'h13;
    localparam logic [CODE_W-1:0] CODE_DASH  = 5'h14;
    localparam logic [CODE_W-1:0] CODE_BLANK = 5'h1E;
    localparam logic [CODE_W-1:0] CODE_BAD   = 5'h1F;

    // Active-low segment patterns, written g..a
    localparam logic [SEG_W-1:0] PAT_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] PAT_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] PAT_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] PAT_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] PAT_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] PAT_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] PAT_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] PAT_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] PAT_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] PAT_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] PAT_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] PAT_B     = 7'b0000011;
    localparam logic [SEG_W-1:0] PAT_C     = 7'b1000110;
    localparam logic [SEG_W-1:0] PAT_D     = 7'b0100001;
    localparam logic [SEG_W-1:0] PAT_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] PAT_F     = 7'b0001110;
    localparam logic [SEG_W-1:0] PAT_L     = 7'b1000111;
    localparam logic [SEG_W-1:0] PAT_H     = 7'b0001001;
    localparam logic [SEG_W-1:0] PAT_P     = 7'b0001100;
    localparam logic [SEG_W-1:0] PAT_U     = 7'b1000001;
    localparam logic [SEG_W-1:0] PAT_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] PAT_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        AN_NONE  = 2'd0,   // no digit lit
        AN_ONE   = 2'd1,   // exactly one anode low
        AN_MULTI = 2'd2    // two or more anodes low
    } an_class_t;

    // Classify an active-low anode vector
    function automatic an_class_t classify_an(input logic [DIGITS-1:0] an_v);
        an_class_t cls;
        case (an_v)
            4'b1111:                            cls = AN_NONE;
            4'b1110, 4'b1101, 4'b1011, 4'b0111: cls = AN_ONE;
            default:                            cls = AN_MULTI;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern to character-code decoder.
// Ports:
//   pattern  in  7  active-low segment lines, bit0 = a ... bit6 = g
//   code     out 5  0x00-0x0F hex, 0x10-0x14 letters/dash, 0x1E blank,
//                   0x1F for any unrecognised pattern
// The letter O shares the pattern of 0 and therefore decodes as 0x00.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0]  pattern,
    output logic [CODE_W-1:0] code
);

    // Pattern lookup
    always_comb begin
        code = CODE_BAD;
        case (pattern)
            PAT_0:     code = 5'h00;
            PAT_1:     code = 5'h01;
            PAT_2:     code = 5'h02;
            PAT_3:     code = 5'h03;
            PAT_4:     code = 5'h04;
            PAT_5:     code = 5'h05;
            PAT_6:     code = 5'h06;
            PAT_7:     code = 5'h07;
            PAT_8:     code = 5'h08;
            PAT_9:     code = 5'h09;
            PAT_A:     code = 5'h0A;
            PAT_B:     code = 5'h0B;
            PAT_C:     code = 5'h0C;
            PAT_D:     code = 5'h0D;
            PAT_E:     code = 5'h0E;
            PAT_F:     code = 5'h0F;
            PAT_L:     code = CODE_L;
            PAT_H:     code = CODE_H;
            PAT_P:     code = CODE_P;
            PAT_U:     code = CODE_U;
            PAT_DASH:  code = CODE_DASH;
            PAT_BLANK: code = CODE_BLANK;
            default:   code = CODE_BAD;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of a 4-digit multiplexed seven-segment bus.
// Synchronises {an,seg}, waits for each scan step to be stable, decodes the
// lit digit into its slot and hands a full (or timed-out partial) frame out
// on a valid/ready interface.
// Ports:
//   CLOCK        in   1   system clock
//   RESET_N      in   1   asynchronous active-low reset
//   an           in   4   anode enables, active-low
//   seg          in   7   segment lines, active-low, bit0 = a ... bit6 = g
//   frame_code   out  20  {d3,d2,d1,d0}, d0 belongs to an[0]
//   frame_valid  out  1   frame_code holds an unaccepted frame
//   frame_ready  in   1   consumer accepts on an edge with frame_valid=1
//   overrun      out  1   sticky: a completed frame was dropped
//   illegal_an   out  1   sticky: a stable sample had several anodes low
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                     CLOCK,
    input  logic                     RESET_N,
    input  logic [DIGITS-1:0]        an,
    input  logic [SEG_W-1:0]         seg,
    output logic [DIGITS*CODE_W-1:0] frame_code,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic                     overrun,
    output logic                     illegal_an
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_FIRE = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    // Input capture and stability tracking
    logic [SAMPLE_W-1:0] sync1_r;
    logic [SAMPLE_W-1:0] sync2_r;
    logic [SAMPLE_W-1:0] prev_r;
    logic [STAB_W-1:0]   stab_r;

    // Frame assembly state
    logic [DIGITS-1:0]             seen_r;
    logic [DIGITS-1:0][CODE_W-1:0] slot_r;
    logic [IDLE_W-1:0]             idle_r;

    // Output registers
    logic [DIGITS*CODE_W-1:0] frame_code_r;
    logic                     frame_valid_r;
    logic                     overrun_r;
    logic                     illegal_an_r;

    // Combinational helpers
    logic [DIGITS-1:0]             an_s;
    logic [SEG_W-1:0]              seg_s;
    logic [CODE_W-1:0]             code_s;
    logic                          strobe_s;
    logic [DIGITS-1:0]             write_mask_s;
    logic                          illegal_hit_s;
    logic [DIGITS-1:0][CODE_W-1:0] slot_next_s;
    logic                          close_s;
    logic                          load_s;

    assign an_s  = sync2_r[SAMPLE_W-1:SEG_W];
    assign seg_s = sync2_r[SEG_W-1:0];

    // Fires once per stable window, on the count STABLE_CYCLES-1 -> STABLE_CYCLES
    assign strobe_s = (sync2_r == prev_r) && (stab_r == STAB_FIRE);

    seg7_decode u_decode (
        .pattern (seg_s),
        .code    (code_s)
    );

    // Classify the strobed sample into a slot write or an illegal-anode flag
    always_comb begin
        write_mask_s  = '0;
        illegal_hit_s = 1'b0;
        if (strobe_s) begin
            case (classify_an(an_s))
                AN_ONE:   write_mask_s  = ~an_s;
                AN_MULTI: illegal_hit_s = 1'b1;
                default:  write_mask_s  = '0;
            endcase
        end else begin
            write_mask_s = '0;
        end
    end

    // Slot contents including this edge's write, so a coincident close sees it
    always_comb begin
        slot_next_s = slot_r;
        for (int i = 0; i < DIGITS; i++) begin
            if (write_mask_s[i]) begin
                slot_next_s[i] = code_s;
            end else begin
                slot_next_s[i] = slot_r[i];
            end
        end
    end

    // Close on a fully populated frame or on idle timeout of a partial one
    assign close_s = (seen_r == {DIGITS{1'b1}}) ||
                     ((seen_r != '0) && (idle_r == IDLE_LAST));

    // A close only reaches the output if the holding register is free this edge
    assign load_s = close_s && (!frame_valid_r || frame_ready);

    // Two-flop synchroniser, previous-sample register and stability counter
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_r <= {SAMPLE_W{1'b1}};
            sync2_r <= {SAMPLE_W{1'b1}};
            prev_r  <= {SAMPLE_W{1'b1}};
            stab_r  <= '0;
        end else begin
            sync1_r <= {an, seg};
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            if (sync2_r != prev_r) begin
                stab_r <= '0;
            end else if (stab_r != STAB_MAX) begin
                stab_r <= stab_r + STAB_W'(1);
            end else begin
                stab_r <= stab_r;
            end
        end
    end

    // Slot, seen-mask and idle-counter bookkeeping for the frame under assembly
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            seen_r <= '0;
            slot_r <= {DIGITS{CODE_BLANK}};
            idle_r <= '0;
        end else if (close_s) begin
            seen_r <= '0;
            slot_r <= {DIGITS{CODE_BLANK}};
            idle_r <= '0;
        end else begin
            seen_r <= seen_r | write_mask_s;
            slot_r <= slot_next_s;
            if ((seen_r == '0) || (write_mask_s != '0)) begin
                idle_r <= '0;
            end else if (idle_r != IDLE_MAX) begin
                idle_r <= idle_r + IDLE_W'(1);
            end else begin
                idle_r <= idle_r;
            end
        end
    end

    // Output holding register, handshake and sticky status flags
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            frame_code_r  <= '0;
            frame_valid_r <= 1'b0;
            overrun_r     <= 1'b0;
            illegal_an_r  <= 1'b0;
        end else begin
            if (load_s) begin
                frame_code_r  <= slot_next_s;
                frame_valid_r <= 1'b1;
            end else if (frame_ready) begin
                frame_code_r  <= frame_code_r;
                frame_valid_r <= 1'b0;
            end else begin
                frame_code_r  <= frame_code_r;
                frame_valid_r <= frame_valid_r;
            end
            if (close_s && !load_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
            if (illegal_hit_s) begin
                illegal_an_r <= 1'b1;
            end else begin
                illegal_an_r <= illegal_an_r;
            end
        end
    end

    assign frame_code  = frame_code_r;
    assign frame_valid = frame_valid_r;
    assign overrun     = overrun_r;
    assign illegal_an  = illegal_an_r;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed self-checking bench for seg_scan_capture with STABLE_CYCLES=4 and
// TIMEOUT_CYCLES=64. Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point, away from the active edge.
module tb_seg_scan_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_ready;
    logic [19:0] frame_code;
    logic        frame_valid;
    logic        overrun;
    logic        illegal_an;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_scan_capture #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .CLOCK       (clk),
        .RESET_N     (rst_n),
        .an          (an),
        .seg         (seg),
        .frame_code  (frame_code),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun),
        .illegal_an  (illegal_an)
    );

    // Drive one scan step for n cycles
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full scan d0..d3, 8 cycles per digit
    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        hold(4'b1110, s0, 8);
        hold(4'b1101, s1, 8);
        hold(4'b1011, s2, 8);
        hold(4'b0111, s3, 8);
    endtask

    // Wait for frame_valid, bounded by a cycle budget
    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && frame_valid !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        an  = 4'b1111;
        seg = 7'b1111111;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(4'b1111, 7'b1111111, 2);
    endtask

    task automatic accept();
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        an          = 4'b1111;
        seg         = 7'b1111111;
        frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (frame_code !== 20'h0) begin bad++; $display("FAIL reset_code got=%h want=%h", frame_code, 20'h0); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", frame_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        total++; if (illegal_an !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", illegal_an); end
        rst_n = 1'b1;
        hold(4'b1111, 7'b1111111, 4);
    endtask

    task automatic test_full_scan();
        logic [19:0] exp;
        exp = {5'h08, 5'h10, 5'h00, 5'h0A};
        scan4(7'b0001000, 7'b1000000, 7'b1000111, 7'b0000000);
        hold(4'b1111, 7'b1111111, 2);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b want=1", frame_valid); end
        total++; if (frame_code !== exp) begin bad++; $display("FAIL full_code got=%h want=%h", frame_code, exp); end
        hold(4'b1111, 7'b1111111, 5);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL full_held_valid got=%b want=1", frame_valid); end
        total++; if (frame_code !== exp) begin bad++; $display("FAIL full_held_code got=%h want=%h", frame_code, exp); end
        accept();
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL full_accept got=%b want=0", frame_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL full_overrun got=%b want=0", overrun); end
        total++; if (illegal_an !== 1'b0) begin bad++; $display("FAIL full_illegal got=%b want=0", illegal_an); end
    endtask

    task automatic test_timeout();
        logic [19:0] exp;
        exp = {5'h1E, 5'h10, 5'h00, 5'h0A};
        for (int r = 0; r < 2; r++) begin
            hold(4'b1011, 7'b1000111, 8);
            hold(4'b1101, 7'b1000000, 8);
            hold(4'b1110, 7'b0001000, 8);
        end
        hold(4'b1111, 7'b1111111, 40);
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b want=0", frame_valid); end
        wait_valid(60);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL timeout_valid got=%b want=1", frame_valid); end
        total++; if (frame_code !== exp) begin bad++; $display("FAIL timeout_code got=%h want=%h", frame_code, exp); end
        accept();
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL timeout_accept got=%b want=0", frame_valid); end
    endtask

    task automatic test_illegal();
        logic [19:0] exp;
        exp = {5'h04, 5'h03, 5'h02, 5'h01};
        pulse_reset();
        hold(4'b0000, 7'b1110110, 10);
        total++; if (illegal_an !== 1'b1) begin bad++; $display("FAIL illegal_flag got=%b want=1", illegal_an); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL illegal_noframe got=%b want=0", frame_valid); end
        scan4(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);
        hold(4'b1111, 7'b1111111, 2);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL illegal_then_valid got=%b want=1", frame_valid); end
        total++; if (frame_code !== exp) begin bad++; $display("FAIL illegal_then_code got=%h want=%h", frame_code, exp); end
        total++; if (illegal_an !== 1'b1) begin bad++; $display("FAIL illegal_sticky got=%b want=1", illegal_an); end
        accept();
    endtask

    task automatic test_glitch();
        logic [19:0] exp;
        exp = {5'h14, 5'h1F, 5'h00, 5'h1E};
        pulse_reset();
        hold(4'b1110, 7'b0001000, 3);
        hold(4'b1101, 7'b1000000, 8);
        hold(4'b1011, 7'b1010101, 8);
        hold(4'b0111, 7'b0111111, 8);
        hold(4'b1111, 7'b1111111, 2);
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL glitch_nofull got=%b want=0", frame_valid); end
        wait_valid(100);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL glitch_valid got=%b want=1", frame_valid); end
        total++; if (frame_code !== exp) begin bad++; $display("FAIL glitch_code got=%h want=%h", frame_code, exp); end
        accept();
    endtask

    task automatic test_overrun();
        logic [19:0] exp1;
        logic [19:0] exp3;
        exp1 = {5'h04, 5'h03, 5'h02, 5'h01};
        exp3 = {5'h12, 5'h11, 5'h0F, 5'h0E};
        pulse_reset();
        scan4(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);
        scan4(7'b0010010, 7'b0000010, 7'b1111000, 7'b0010000);
        hold(4'b1111, 7'b1111111, 2);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL overrun_valid got=%b want=1", frame_valid); end
        total++; if (frame_code !== exp1) begin bad++; $display("FAIL overrun_code got=%h want=%h", frame_code, exp1); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_flag got=%b want=1", overrun); end
        // Third scan: ready asserted only on the edge that closes the frame
        hold(4'b1110, 7'b0000110, 8);
        hold(4'b1101, 7'b0001110, 8);
        hold(4'b1011, 7'b0001001, 8);
        hold(4'b0111, 7'b0001100, 7);
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL sameedge_valid got=%b want=1", frame_valid); end
        total++; if (frame_code !== exp3) begin bad++; $display("FAIL sameedge_code got=%h want=%h", frame_code, exp3); end
        hold(4'b1111, 7'b1111111, 3);
        total++; if (frame_code !== exp3) begin bad++; $display("FAIL sameedge_stable got=%h want=%h", frame_code, exp3); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
    endtask

    task automatic test_reset_mid();
        logic [19:0] exp_part;
        logic [19:0] exp_full;
        exp_part = {5'h13, 5'h0D, 5'h1E, 5'h1E};
        exp_full = {5'h13, 5'h0D, 5'h0C, 5'h0B};
        // A frame is still pending from the previous test; capture two digits
        hold(4'b1110, 7'b1111000, 8);
        hold(4'b1101, 7'b0010000, 8);
        an  = 4'b1111;
        seg = 7'b1111111;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (frame_code !== 20'h0) begin bad++; $display("FAIL midrst_code got=%h want=%h", frame_code, 20'h0); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", frame_valid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL midrst_overrun got=%b want=0", overrun); end
        total++; if (illegal_an !== 1'b0) begin bad++; $display("FAIL midrst_illegal got=%b want=0", illegal_an); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(4'b1111, 7'b1111111, 2);
        hold(4'b1011, 7'b0100001, 8);
        hold(4'b0111, 7'b1000001, 8);
        hold(4'b1111, 7'b1111111, 2);
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL midrst_nostale_early got=%b want=0", frame_valid); end
        wait_valid(100);
        total++; if (frame_code !== exp_part) begin bad++; $display("FAIL midrst_partial got=%h want=%h", frame_code, exp_part); end
        accept();
        scan4(7'b0000011, 7'b1000110, 7'b0100001, 7'b1000001);
        hold(4'b1111, 7'b1111111, 2);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL midrst_full_valid got=%b want=1", frame_valid); end
        total++; if (frame_code !== exp_full) begin bad++; $display("FAIL midrst_full_code got=%h want=%h", frame_code, exp_full); end
        accept();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_full_scan();
        test_timeout();
        test_illegal();
        test_glitch();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
